mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and the data cache.
- Arbitrates their miss/write-back requests onto the single RAM port.
- Returns per-port wait/load handshakes to the caches.
- Data port has priority; a starvation counter guarantees instruction forward progress.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter : icache/dcache to single RAM port arbiter, data-priority with
//               starvation guard for instruction fetch.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int unsigned     c_SW         = $clog2(STARVE_MAX + 1);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_IGRANT = 2'd1;
  localparam logic [1:0] c_DGRANT = 2'd2;

  localparam logic [1:0] c_RAM_ACCESS = 2'd2;
  localparam logic [1:0] c_RAM_ERROR  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [c_SW-1:0] r_starve;
  logic [c_SW-1:0] w_starve_next;
  logic            r_err;
  logic            w_err_next;

  logic w_dreq;
  logic w_access;
  logic w_ram_err;
  logic w_dgo;

  assign w_dreq    = dREN | dWEN;
  assign w_access  = (ramstate == c_RAM_ACCESS);
  assign w_ram_err = (ramstate == c_RAM_ERROR);
  // Data wins unless the instruction port has been passed over STARVE_MAX times.
  assign w_dgo     = w_dreq & ((r_starve < c_STARVE_MAX) | ~iREN);

  assign err = r_err;

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve;
    w_err_next    = r_err;
    iwait         = 1'b1;
    dwait         = 1'b1;
    iload         = '0;
    dload         = '0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;

    case (r_state)
      c_IDLE: begin
        if (w_dgo) begin
          w_state_next = c_DGRANT;
        end else if (iREN) begin
          w_state_next = c_IGRANT;
        end
      end

      c_DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if ((dREN & dWEN) | w_ram_err) begin
          w_err_next = 1'b1;
        end
        if (!w_dreq) begin
          w_state_next = c_IDLE;
        end else if (w_access) begin
          dwait        = 1'b0;
          dload        = dWEN ? '0 : ramload;
          w_state_next = c_IDLE;
          if (iREN) begin
            w_starve_next = (r_starve == c_STARVE_MAX) ? c_STARVE_MAX
                                                       : r_starve + 1'b1;
          end else begin
            w_starve_next = '0;
          end
        end
      end

      c_IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (w_ram_err) begin
          w_err_next = 1'b1;
        end
        // A dropped iREN is a branch redirect: abandon without completing.
        if (!iREN) begin
          w_state_next = c_IDLE;
        end else if (w_access) begin
          iwait         = 1'b0;
          iload         = ramload;
          w_state_next  = c_IDLE;
          w_starve_next = '0;
        end
      end

      default: begin
        w_state_next = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= c_IDLE;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
      r_err    <= w_err_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int n_checks = 0;
  int n_errs   = 0;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .STARVE_MAX (4),
    .ADDR_W     (32),
    .DATA_W     (32)
  ) u_dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    tick();
    #3;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    nRST = 1'b1;

    // Instruction fetch with two BUSY cycles then ACCESS.
    iREN = 1'b1; iaddr = 32'h40;
    #3;
    chk("t1_idle_ramREN", 32'(ramREN), 32'd0);
    tick();
    ramstate = BUSY;
    #3;
    chk("t1_c1_ramREN", 32'(ramREN), 32'd1);
    chk("t1_c1_ramaddr", ramaddr, 32'h40);
    chk("t1_c1_iwait", 32'(iwait), 32'd1);
    chk("t1_c1_iload", iload, 32'd0);
    tick();
    #3;
    chk("t1_c2_iwait", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #3;
    chk("t1_c3_iwait", 32'(iwait), 32'd0);
    chk("t1_c3_iload", iload, 32'hDEADBEEF);
    chk("t1_c3_dwait", 32'(dwait), 32'd1);
    tick();
    iREN = 1'b0; ramstate = FREE;
    #3;
    chk("t1_back_idle_ramREN", 32'(ramREN), 32'd0);
    chk("t1_back_idle_iwait", 32'(iwait), 32'd1);
    tick();

    // Simultaneous requests: data first, then instruction after one bubble.
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
    #3;
    tick();
    ramstate = ACCESS; ramload = 32'h0000CAFE;
    #3;
    chk("t2_dgrant_ramaddr", ramaddr, 32'h100);
    chk("t2_dgrant_ramREN", 32'(ramREN), 32'd1);
    chk("t2_dwait", 32'(dwait), 32'd0);
    chk("t2_dload", dload, 32'h0000CAFE);
    chk("t2_iwait_held", 32'(iwait), 32'd1);
    tick();
    dREN = 1'b0; ramstate = FREE;
    #3;
    chk("t2_bubble_ramREN", 32'(ramREN), 32'd0);
    tick();
    ramstate = ACCESS; ramload = 32'h11112222;
    #3;
    chk("t2_igrant_ramaddr", ramaddr, 32'h44);
    chk("t2_iwait", 32'(iwait), 32'd0);
    chk("t2_iload", iload, 32'h11112222);
    chk("t2_dwait_held", 32'(dwait), 32'd1);
    chk("t2_dload_zero", dload, 32'd0);
    tick();
    ramstate = FREE;

    // Starvation guard: four data writes, then instruction is forced in.
    dWEN = 1'b1; daddr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      dstore = 32'hA000_0000 + 32'(k);
      ramstate = FREE;
      #3;
      chk("t3_idle_ramWEN", 32'(ramWEN), 32'd0);
      tick();
      ramstate = ACCESS;
      #3;
      chk("t3_wr_ramWEN", 32'(ramWEN), 32'd1);
      chk("t3_wr_ramstore", ramstore, 32'hA000_0000 + 32'(k));
      chk("t3_wr_dwait", 32'(dwait), 32'd0);
      chk("t3_wr_dload", dload, 32'd0);
      tick();
    end
    ramstate = FREE;
    #3;
    tick();
    ramstate = ACCESS; ramload = 32'h5555AAAA;
    #3;
    chk("t3_forced_ramREN", 32'(ramREN), 32'd1);
    chk("t3_forced_ramWEN", 32'(ramWEN), 32'd0);
    chk("t3_forced_ramaddr", ramaddr, 32'h44);
    chk("t3_forced_iwait", 32'(iwait), 32'd0);
    chk("t3_forced_dwait", 32'(dwait), 32'd1);
    tick();
    ramstate = FREE; dstore = 32'hA000_0004;
    #3;
    tick();
    ramstate = ACCESS;
    #3;
    chk("t3_fifth_ramWEN", 32'(ramWEN), 32'd1);
    chk("t3_fifth_dwait", 32'(dwait), 32'd0);
    tick();
    dWEN = 1'b0; iREN = 1'b0; ramstate = FREE;
    #3;
    tick();

    // Branch redirect aborts an instruction grant.
    iREN = 1'b1; iaddr = 32'h80;
    #3;
    tick();
    ramstate = BUSY;
    #3;
    chk("t4_c1_ramREN", 32'(ramREN), 32'd1);
    tick();
    iREN = 1'b0;
    #3;
    chk("t4_c2_iwait", 32'(iwait), 32'd1);
    tick();
    #3;
    chk("t4_c3_ramREN", 32'(ramREN), 32'd0);
    chk("t4_c3_iwait", 32'(iwait), 32'd1);
    chk("t4_err", 32'(err), 32'd0);
    tick();
    ramstate = FREE;

    // Read and write together: write wins, error latched.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h8; dstore = 32'h12345678;
    #3;
    tick();
    ramstate = BUSY;
    #3;
    chk("t5_ramWEN", 32'(ramWEN), 32'd1);
    chk("t5_ramREN", 32'(ramREN), 32'd0);
    chk("t5_ramaddr", ramaddr, 32'h8);
    chk("t5_ramstore", ramstore, 32'h12345678);
    tick();
    ramstate = ACCESS; ramload = 32'hFFFF0000;
    #3;
    chk("t5_err_set", 32'(err), 32'd1);
    chk("t5_dwait", 32'(dwait), 32'd0);
    chk("t5_dload_write", dload, 32'd0);
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #3;
    chk("t5_err_sticky", 32'(err), 32'd1);
    tick();

    // Asynchronous reset in the middle of a data grant.
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h0BADF00D;
    #3;
    tick();
    ramstate = BUSY;
    #3;
    chk("t6_pre_ramWEN", 32'(ramWEN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("t6_rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("t6_rst_ramREN", 32'(ramREN), 32'd0);
    chk("t6_rst_dwait", 32'(dwait), 32'd1);
    chk("t6_rst_err", 32'(err), 32'd0);
    tick();
    nRST = 1'b1; iREN = 1'b1; iaddr = 32'hC0; ramstate = FREE;
    #3;
    chk("t6_idle_ramWEN", 32'(ramWEN), 32'd0);
    tick();
    ramstate = ACCESS;
    #3;
    chk("t6_first_grant_data", 32'(ramWEN), 32'd1);
    chk("t6_first_dwait", 32'(dwait), 32'd0);
    tick();
    dWEN = 1'b0; ramstate = FREE;
    #3;
    tick();

    // RAM error during a grant behaves like BUSY and latches err.
    ramstate = ERROR;
    #3;
    chk("t7_err_ramREN", 32'(ramREN), 32'd1);
    chk("t7_err_iwait", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'h77778888;
    #3;
    chk("t7_err_flag", 32'(err), 32'd1);
    chk("t7_iwait", 32'(iwait), 32'd0);
    chk("t7_iload", iload, 32'h77778888);
    tick();
    iREN = 1'b0; ramstate = FREE;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
